// File: rtl/ifq_pkg.sv
// Shared constants and types for the instruction prefetch queue.
// The pointer and count types are sized for the default queue depth.
package ifq_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned IFQ_DEPTH  = 4;

    typedef logic [$clog2(IFQ_DEPTH)-1:0] ifq_ptr_t;
    typedef logic [$clog2(IFQ_DEPTH):0]   ifq_cnt_t;

    // Classification of one cycle's lookup, which selects the state update.
    typedef enum logic [1:0] {
        UPD_HIT,
        UPD_PENDING,
        UPD_REDIRECT
    } ifq_upd_e;

endpackage

// File: rtl/ifetch_queue_if.sv
// Instruction-memory request/acknowledge channel of the prefetch queue.
// The master is the queue; the slave is the instruction memory.
interface ifetch_queue_if #(
    parameter int W = 32
);
    logic         req;
    logic [W-1:0] addr;
    logic         ack;
    logic [31:0]  rdata;

    modport master (output req, output addr, input  ack, input  rdata);
    modport slave  (input  req, input  addr, output ack, output rdata);

endinterface

// File: rtl/ifq_ram.sv
// DEPTH x 32 storage for the prefetch queue.
// It has one synchronous write port and one asynchronous read port.
module ifq_ram #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [PW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] data_q [DEPTH];

    // NOTE: the array has no reset. Only indices below count are ever read, and reset clears count.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment lets every flop sample pre-edge values, whatever the process order.
        if (we_i) data_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = data_q[raddr_i];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue between instruction memory and the fetch stage.
// Defining IFQ_PERF_EN adds the hit, miss and redirect event counters.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int           W        = 32,
    parameter int           DEPTH    = IFQ_DEPTH,
    parameter logic [W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  pc_i,
    output logic [31:0]   instr_o,
    output logic          hit_o,
    output logic          stall_o,
    ifetch_queue_if.master mem
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0]   hit_cnt_o,
    output logic [31:0]   miss_cnt_o,
    output logic [31:0]   redirect_cnt_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = W - 2;

    logic [W-1:0]  base_q, base_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [AW-1:0] k_full;
    logic [PW-1:0] k;
    logic          hit;
    logic          pending;
    logic          req;
    logic          push;
    logic          ram_we;
    logic [31:0]   ram_rdata;
    logic [W-1:0]  pc_aligned;
    ifq_upd_e      upd;

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^pc_i[1:0];

    assign pc_aligned = {pc_i[W-1:2], 2'b00};

    // Word distance from the oldest entry. It wraps, so a PC behind base gives a large k and misses.
    always_comb begin
        k_full  = pc_i[W-1:2] - base_q[W-1:2];
        k       = k_full[PW-1:0];
        hit     = !reset && (k_full < AW'(count_q));
        pending = (count_q == '0) && (k_full == '0);
        req     = !reset && (count_q < CW'(DEPTH));
        push    = req && mem.ack;
    end

    assign hit_o    = hit;
    assign stall_o  = !hit;
    assign instr_o  = hit ? ram_rdata : NOP_INSTR;
    assign mem.req  = req;
    assign mem.addr = reset ? RESET_PC : base_q + W'(count_q) * W'(WORD_BYTES);

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case infers a latch.
        base_d   = base_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ram_we   = 1'b0;

        if (hit)          upd = UPD_HIT;
        else if (pending) upd = UPD_PENDING;
        else              upd = UPD_REDIRECT;

        case (upd)
            UPD_HIT: begin
                base_d   = base_q + W'(k) * W'(WORD_BYTES);
                rd_ptr_d = rd_ptr_q + k;
                count_d  = count_q - CW'(k) + CW'(push);
                ram_we   = push;
            end
            UPD_PENDING: begin
                count_d = count_q + CW'(push);
                ram_we  = push;
            end
            default: begin
                // Any word arriving in this cycle belongs to the old stream and is dropped.
                base_d   = pc_aligned;
                count_d  = '0;
                rd_ptr_d = wr_ptr_q;
            end
        endcase

        if (ram_we) wr_ptr_d = wr_ptr_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q   <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            base_q   <= base_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    ifq_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (mem.rdata),
        .raddr_i (rd_ptr_q + k),
        .rdata_o (ram_rdata)
    );

`ifdef IFQ_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        hit_cnt_d      = hit_cnt_q + 32'(hit);
        miss_cnt_d     = miss_cnt_q + 32'(!hit);
        redirect_cnt_d = redirect_cnt_q + 32'(upd == UPD_REDIRECT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q      <= '0;
            miss_cnt_q     <= '0;
            redirect_cnt_q <= '0;
        end else begin
            hit_cnt_q      <= hit_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign hit_cnt_o      = hit_cnt_q;
    assign miss_cnt_o     = miss_cnt_q;
    assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios followed by random PC/ack/reset traffic.
// A queue-of-words reference model supplies every expected value.
module tb_ifetch_queue;
    import ifq_pkg::*;

    localparam int          W      = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        hit;
    logic        stall;

    ifetch_queue_if #(.W(W)) mem_if ();

`ifdef IFQ_PERF_EN
    logic [31:0] hit_cnt, miss_cnt, redirect_cnt;
`endif

    ifetch_queue #(.W(W), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk     (clk),
        .reset   (reset),
        .pc_i    (pc),
        .instr_o (instr),
        .hit_o   (hit),
        .stall_o (stall),
        .mem     (mem_if)
`ifdef IFQ_PERF_EN
        ,
        .hit_cnt_o      (hit_cnt),
        .miss_cnt_o     (miss_cnt),
        .redirect_cnt_o (redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign mem_if.rdata = mem_word(mem_if.addr);

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: base address of the oldest word plus the buffered words in order.
    logic [31:0] m_base;
    logic [31:0] m_q[$];

    // Values sampled in the most recent step, for the directed checks.
    logic [31:0] last_instr, last_addr;
    logic        last_hit, last_req, last_ack, last_redirect;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [31:0] p, input logic ack);
        logic [29:0] kk;
        int          k;
        logic        e_hit, e_req;
        logic [31:0] e_instr, e_addr;
        @(negedge clk);
        reset      = rst;
        pc         = p;
        mem_if.ack = ack;
        #1;
        kk = p[31:2] - m_base[31:2];
        k  = int'(kk);
        if (rst) begin
            e_hit   = 1'b0;
            e_instr = 32'h0;
            e_req   = 1'b0;
            e_addr  = RST_PC;
        end else begin
            e_hit   = (k < m_q.size());
            e_instr = e_hit ? m_q[k] : 32'h0;
            e_req   = (m_q.size() < DEPTH);
            e_addr  = m_base + 32'(4 * m_q.size());
        end
        chk("hit",   32'(hit),        32'(e_hit));
        chk("stall", 32'(stall),      32'(!e_hit));
        chk("instr", instr,           e_instr);
        chk("req",   32'(mem_if.req), 32'(e_req));
        chk("addr",  mem_if.addr,     e_addr);
        last_instr    = instr;
        last_addr     = mem_if.addr;
        last_hit      = hit;
        last_req      = mem_if.req;
        last_ack      = ack;
        last_redirect = !rst && !e_hit && !(m_q.size() == 0 && kk == 30'd0);
        @(posedge clk);
        if (rst) begin
            m_base = RST_PC;
            m_q.delete();
        end else if (e_hit) begin
            repeat (k) void'(m_q.pop_front());
            m_base = m_base + 32'(4 * k);
            if (e_req && ack) m_q.push_back(mem_word(e_addr));
        end else if (!last_redirect) begin
            if (e_req && ack) m_q.push_back(mem_word(e_addr));
        end else begin
            m_base = {p[31:2], 2'b00};
            m_q.delete();
        end
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] prev_addr;
        logic        prev_hold;
        int          r;

        reset      = 1'b1;
        pc         = 32'h0;
        mem_if.ack = 1'b0;
        m_base     = RST_PC;

        // Reset, then a zero-wait memory streams sequential words.
        step(1'b1, 32'h0, 1'b1);
        step(1'b1, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("tp1_first_addr", last_addr, 32'h0);
        chk("tp1_first_req", 32'(last_req), 32'd1);
        step(1'b0, 32'h0, 1'b1);
        chk("tp1_first_hit", 32'(last_hit), 32'd1);
        chk("tp1_first_instr", last_instr, 32'hA5A5_0000);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 32'(4 * i), 1'b1);
            chk("tp1_seq_hit", 32'(last_hit), 32'd1);
        end

        // PC held at 0: the queue fills and then stops requesting.
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
        chk("full_no_req", 32'(last_req), 32'd0);
        chk("full_instr", last_instr, 32'hA5A5_0000);

        // Jump to 0x100 from a full queue.
        step(1'b0, 32'h100, 1'b1);
        chk("jump_stall", 32'(stall), 32'd1);
        chk("jump_instr", last_instr, 32'h0);
        step(1'b0, 32'h100, 1'b1);
        chk("jump_addr", last_addr, 32'h100);
        step(1'b0, 32'h100, 1'b1);
        chk("jump_hit", 32'(last_hit), 32'd1);
        chk("jump_hit_instr", last_instr, 32'hA5A5_0100);

        // Three words buffered with ack low, then skip forward to 0x8.
        step(1'b1, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h8, 1'b0);
        chk("skip_hit", 32'(last_hit), 32'd1);
        chk("skip_instr", last_instr, 32'hA5A5_0008);
        step(1'b0, 32'h8, 1'b0);
        chk("skip_addr_after", last_addr, 32'hC);
        chk("skip_still_hit", 32'(last_hit), 32'd1);

        // Slow memory: ack once every third cycle.
        p = 32'h200;
        prev_hold = 1'b0;
        prev_addr = 32'h0;
        for (int i = 0; i < 36; i++) begin
            step(1'b0, p, (i % 3) == 2);
            if (prev_hold) chk("addr_stable", last_addr, prev_addr);
            prev_hold = last_req && !last_ack && !last_redirect;
            prev_addr = last_addr;
            if (last_hit) p = p + 32'd4;
        end

        // Reset during a requesting, acknowledged cycle discards the transfer.
        step(1'b0, p, 1'b1);
        step(1'b1, p, 1'b1);
        chk("rst_no_req", 32'(last_req), 32'd0);
        step(1'b0, 32'h4, 1'b1);
        chk("post_rst_addr", last_addr, RST_PC);
        chk("post_rst_miss", 32'(last_hit), 32'd0);

        // Sequential fetch across the top of the address space.
        p = 32'hFFFF_FFF8;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, p, 1'b1);
            if (last_hit) p = p + 32'd4;
        end
        chk("wrap_reached_zero", 32'(p < 32'h100), 32'd1);

        // Random traffic.
        p = 32'h1000;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            step(r == 0, p, $urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 15));
            if (r < 10) begin
                if (last_hit) p = p + 32'd4;
            end else if (r == 10) begin
                p = $urandom;
            end else if (r == 11) begin
                p = p - 32'd4;
            end else if (r == 12) begin
                p = p | 32'($urandom_range(0, 3));
            end else if (r == 13) begin
                p = m_base + 32'(4 * $urandom_range(0, 3));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction prefetch queue between instruction memory and the pipelined datapath's fetch stage.
- Consumes the fetch-stage PC (`instradr`) and produces the fetched instruction word (`instrF`).
- Prefetches sequential words over a req/ack memory handshake into a circular buffer.
- Reports a stall when the requested PC is not buffered; the stall is ORed into the datapath's fetch/decode stalls.

Parameters:
- W, 32, address width.
- DEPTH, 4, queue entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_i  in  W  fetch-stage PC (`instradr`); bits [1:0] ignored.
- instr_o  out  32  instruction at pc_i; drives `instrF`.
- hit_o  out  1  pc_i found in queue this cycle.
- stall_o  out  1  equals ~hit_o; ORed into StallF/StallD.
- mem_req_o  out  1  fetch request.
- mem_addr_o  out  W  word-aligned fetch address.
- mem_ack_i  in  1  memory accepts; data valid the same cycle.
- mem_rdata_i  in  32  fetched word.

Behaviour:
- Interface: single clock `clk`; `reset` is synchronous and active-high.
- State:
  - base (W, aligned): address of the oldest entry.
  - count (0..DEPTH).
  - rd_ptr/wr_ptr (log2 DEPTH): circular pointers into the data RAM.
  - Entry i holds the word at address base+4*i, mod 2^W.
- Hit lookup (combinational):
  - hit when k = (pc_i[W-1:2] - base[W-1:2]) mod 2^(W-2) satisfies k < count.
  - On hit: instr_o = entry k.
  - On miss: instr_o = 32'h0 (NOP), hit_o = 0, stall_o = 1.
- Fetch request:
  - mem_req_o = (count < DEPTH) && !reset.
  - mem_addr_o = base + 4*count.
  - Transfer occurs only when mem_req_o && mem_ack_i.
  - While mem_req_o is high and no ack arrives, mem_addr_o stays stable; the only exceptions are a redirect or reset.
- Clock-edge update, hit case (k older entries popped, push = transfer):
  - base += 4*k; rd_ptr += k; count = count - k + push.
  - On push, mem_rdata_i is written at wr_ptr and wr_ptr increments.
  - Simultaneous pop and push is legal at any count, including full.
- Clock-edge update, pending miss (count==0 && base==pc_i aligned):
  - No state change except push.
  - A transfer in this cycle makes the next cycle hit.
- Clock-edge update, redirect (any other miss):
  - base = pc_i & ~3; count = 0; rd_ptr = wr_ptr.
  - Any transfer in the same cycle is discarded.
  - The request for pc_i issues next cycle.
  - Minimum miss penalty is 2 stall cycles with zero-wait memory.
- Boundaries:
  - Full (count==DEPTH): no request.
  - Empty: every lookup misses.
  - Pointers wrap mod DEPTH; addresses wrap mod 2^W (0xFFFF_FFFC+4 = 0).
- Reset:
  - On any reset cycle, including mid-transfer: count=0, base=RESET_PC, pointers=0, transfer discarded, mem_req_o=0.
  - Outputs during reset: hit_o=0, stall_o=1, instr_o=0, mem_addr_o=RESET_PC.
  - First request issues in the cycle after reset deasserts.

Optional Feature:
- Macro IFQ_PERF_EN.
- Defined:
  - Adds three 32-bit output ports: hit_cnt_o, miss_cnt_o, redirect_cnt_o.
  - All three are cleared by reset and increment on hit cycles, miss cycles and redirect cycles respectively.
  - All three wrap at 2^32.
- Undefined: ports and counters are absent; core behaviour is identical.

Decomposition:
- Package ifq_pkg:
  - NOP_INSTR = 32'h0.
  - WORD_BYTES = 4.
  - typedef ifq_ptr_t (log2 DEPTH bits).
  - typedef ifq_cnt_t (log2 DEPTH + 1 bits).
- Sub-module ifq_ram:
  - DEPTH x 32 register array.
  - One synchronous write port, one asynchronous read port addressed by rd_ptr+k.
- All control stays in ifetch_queue.

Test Plan:
- Reset with RESET_PC=0, ack always high, memory returns rdata = addr ^ 32'hA5A5_0000:
  - cycle 1 after reset: mem_addr_o=0, transfer.
  - cycle 2: pc_i=0 hits with instr 32'hA5A5_0000.
  - Sequential pc_i then hits every cycle.
- Queue holding 0x00–0x0C, pc_i=0x100:
  - that cycle: stall_o=1, instr_o=0.
  - next cycle: mem_addr_o=0x100.
  - following cycle: hit with 32'hA5A5_0100.
- Queue holding 0x0,0x4,0x8 (count 3, ack low), pc_i jumps 0x0→0x8:
  - hit.
  - after the edge: count=1, base=0x8, mem_addr_o=0xC.
- ack high only every third cycle:
  - mem_addr_o stays constant across non-ack cycles.
  - stall_o is asserted until the needed word transfers.
- pc_i held at 0x0:
  - queue fills to 4, then mem_req_o=0.
  - no overwrite; instr_o stays the 0x0 word.
- reset asserted in a req&&ack cycle:
  - data discarded; count=0.
  - mem_req_o=0 during reset.
  - first post-reset request is to RESET_PC.
